// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: ID-side inputs and staged EX/MEM/WB control outputs of pipe_ctrl_unit
// master: core side, drives ID_IR/ID_VALID/EX_FLUSH and observes STALL and stage controls
// slave : pipe_ctrl_unit, consumes ID inputs and drives STALL and stage controls
interface pipe_ctrl_if;
  logic [31:0] ID_IR;
  logic        ID_VALID;
  logic        EX_FLUSH;
  logic        STALL;
  logic        EX_REG_WRITE;
  logic        EX_MEM_WRITE;
  logic        EX_MEM_READ;
  logic [1:0]  EX_RF_SEL;
  logic [3:0]  EX_ALU_FUN;
  logic        EX_ALU_SRCA;
  logic [1:0]  EX_ALU_SRCB;
  logic [1:0]  EX_PC_SEL;
  logic [2:0]  EX_FUNC3;
  logic [4:0]  EX_RD;
  logic        EX_ILLEGAL;
  logic        MEM_REG_WRITE;
  logic        MEM_MEM_WRITE;
  logic        MEM_MEM_READ;
  logic [1:0]  MEM_RF_SEL;
  logic [2:0]  MEM_FUNC3;
  logic [4:0]  MEM_RD;
  logic        WB_REG_WRITE;
  logic [1:0]  WB_RF_SEL;
  logic [4:0]  WB_RD;
  modport master (
    output ID_IR, ID_VALID, EX_FLUSH,
    input  STALL, EX_REG_WRITE, EX_MEM_WRITE, EX_MEM_READ, EX_RF_SEL, EX_ALU_FUN,
           EX_ALU_SRCA, EX_ALU_SRCB, EX_PC_SEL, EX_FUNC3, EX_RD, EX_ILLEGAL,
           MEM_REG_WRITE, MEM_MEM_WRITE, MEM_MEM_READ, MEM_RF_SEL, MEM_FUNC3, MEM_RD,
           WB_REG_WRITE, WB_RF_SEL, WB_RD
  );
  modport slave (
    input  ID_IR, ID_VALID, EX_FLUSH,
    output STALL, EX_REG_WRITE, EX_MEM_WRITE, EX_MEM_READ, EX_RF_SEL, EX_ALU_FUN,
           EX_ALU_SRCA, EX_ALU_SRCB, EX_PC_SEL, EX_FUNC3, EX_RD, EX_ILLEGAL,
           MEM_REG_WRITE, MEM_MEM_WRITE, MEM_MEM_READ, MEM_RF_SEL, MEM_FUNC3, MEM_RD,
           WB_REG_WRITE, WB_RF_SEL, WB_RD
  );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: RV32I decode, load-use stall and ID/EX, EX/MEM, MEM/WB control registers
// CLK, RST: clock and synchronous active-high reset
// p (pipe_ctrl_if.slave): ID instruction/valid/flush in; STALL and per-stage controls out
module pipe_ctrl_unit #(
  parameter bit HAZARD_EN      = 1'b1,
  parameter bit X0_WB_SUPPRESS = 1'b1,
  parameter bit ILLEGAL_BUBBLE = 1'b1
) (
  input logic         CLK,
  input logic         RST,
  pipe_ctrl_if.slave  p
);
  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic [1:0] rf_sel;
    logic [3:0] alu_fun;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] pc_sel;
    logic [2:0] func3;
    logic [4:0] rd;
    logic       illegal;
  } ex_t;
  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic [1:0] rf_sel;
    logic [2:0] func3;
    logic [4:0] rd;
  } mem_t;
  typedef struct packed {
    logic       reg_write;
    logic [1:0] rf_sel;
    logic [4:0] rd;
  } wb_t;
  ex_t  dec, ex_d, ex_q;
  mem_t mem_d, mem_q;
  wb_t  wb_d, wb_q;
  logic legal, use1, use2, stall;
  logic [6:0] op;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  logic unused_ir;
  assign op  = p.ID_IR[6:0];
  assign rd  = p.ID_IR[11:7];
  assign f3  = p.ID_IR[14:12];
  assign rs1 = p.ID_IR[19:15];
  assign rs2 = p.ID_IR[24:20];
  assign unused_ir = ^{p.ID_IR[31], p.ID_IR[29:25]};
  always_comb begin
    dec = '0;
    dec.func3 = f3;
    dec.rd = rd;
    legal = 1'b1;
    use1 = 1'b0;
    use2 = 1'b0;
    case (op)
      7'b0110011: begin
        dec.alu_fun = {p.ID_IR[30], f3};
        dec.rf_sel = 2'b11;
        dec.reg_write = 1'b1;
        use1 = 1'b1;
        use2 = 1'b1;
      end
      7'b0010011: begin
        // only shifts-right use ir[30]; an ADDI immediate bit must not turn into SUB
        dec.alu_fun = {p.ID_IR[30] & (f3 == 3'b101), f3};
        dec.srcb = 2'b01;
        dec.rf_sel = 2'b11;
        dec.reg_write = 1'b1;
        use1 = 1'b1;
      end
      7'b0000011: begin
        dec.srcb = 2'b01;
        dec.mem_read = 1'b1;
        dec.rf_sel = 2'b10;
        dec.reg_write = 1'b1;
        use1 = 1'b1;
      end
      7'b0100011: begin
        dec.srcb = 2'b10;
        dec.mem_write = 1'b1;
        use1 = 1'b1;
        use2 = 1'b1;
      end
      7'b0110111: begin
        dec.alu_fun = 4'b1001;
        dec.srca = 1'b1;
        dec.rf_sel = 2'b11;
        dec.reg_write = 1'b1;
      end
      7'b0010111: begin
        dec.srca = 1'b1;
        dec.srcb = 2'b11;
        dec.rf_sel = 2'b11;
        dec.reg_write = 1'b1;
      end
      7'b1101111: begin
        dec.pc_sel = 2'b10;
        dec.reg_write = 1'b1;
      end
      7'b1100111: begin
        dec.pc_sel = 2'b11;
        dec.srcb = 2'b01;
        dec.reg_write = 1'b1;
        use1 = 1'b1;
      end
      7'b1100011: begin
        dec.pc_sel = 2'b01;
        use1 = 1'b1;
        use2 = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    if (X0_WB_SUPPRESS && rd == 5'd0) dec.reg_write = 1'b0;
  end
  assign stall = HAZARD_EN && p.ID_VALID && !p.EX_FLUSH && ex_q.mem_read && ex_q.rd != 5'd0 &&
                 ((use1 && rs1 == ex_q.rd) || (use2 && rs2 == ex_q.rd));
  always_comb begin
    ex_d = '0;
    if (!(p.EX_FLUSH || stall || !p.ID_VALID)) begin
      ex_d = legal ? dec : '0;
      ex_d.illegal = !legal && ILLEGAL_BUBBLE;
    end
    mem_d = '{ex_q.reg_write, ex_q.mem_write, ex_q.mem_read, ex_q.rf_sel, ex_q.func3, ex_q.rd};
    wb_d = '{mem_q.reg_write, mem_q.rf_sel, mem_q.rd};
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      ex_q <= '0;
      mem_q <= '0;
      wb_q <= '0;
    end else begin
      ex_q <= ex_d;
      mem_q <= mem_d;
      wb_q <= wb_d;
    end
  end
  assign p.STALL         = stall;
  assign p.EX_REG_WRITE  = ex_q.reg_write;
  assign p.EX_MEM_WRITE  = ex_q.mem_write;
  assign p.EX_MEM_READ   = ex_q.mem_read;
  assign p.EX_RF_SEL     = ex_q.rf_sel;
  assign p.EX_ALU_FUN    = ex_q.alu_fun;
  assign p.EX_ALU_SRCA   = ex_q.srca;
  assign p.EX_ALU_SRCB   = ex_q.srcb;
  assign p.EX_PC_SEL     = ex_q.pc_sel;
  assign p.EX_FUNC3      = ex_q.func3;
  assign p.EX_RD         = ex_q.rd;
  assign p.EX_ILLEGAL    = ex_q.illegal;
  assign p.MEM_REG_WRITE = mem_q.reg_write;
  assign p.MEM_MEM_WRITE = mem_q.mem_write;
  assign p.MEM_MEM_READ  = mem_q.mem_read;
  assign p.MEM_RF_SEL    = mem_q.rf_sel;
  assign p.MEM_FUNC3     = mem_q.func3;
  assign p.MEM_RD        = mem_q.rd;
  assign p.WB_REG_WRITE  = wb_q.reg_write;
  assign p.WB_RF_SEL     = wb_q.rf_sel;
  assign p.WB_RD         = wb_q.rd;
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb_pipe_ctrl_unit: directed checks of decode, hazard stall, flush, illegal and reset behaviour
module tb_pipe_ctrl_unit;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  pipe_ctrl_if a ();
  pipe_ctrl_if b ();
  assign b.ID_IR    = a.ID_IR;
  assign b.ID_VALID = a.ID_VALID;
  assign b.EX_FLUSH = a.EX_FLUSH;
  pipe_ctrl_unit u_a (.CLK(clk), .RST(rst), .p(a));
  pipe_ctrl_unit #(.HAZARD_EN(1'b0), .X0_WB_SUPPRESS(1'b0), .ILLEGAL_BUBBLE(1'b0)) u_b (.CLK(clk), .RST(rst), .p(b));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic [31:0] ir, input logic v, input logic f);
    a.ID_IR = ir;
    a.ID_VALID = v;
    a.EX_FLUSH = f;
    #1;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1;
    drive(32'h0, 1'b0, 1'b0);
    tick();
    tick();
    chk("rst_stall", a.STALL, 0);
    chk("rst_ex_rw", a.EX_REG_WRITE, 0);
    chk("rst_pcsel", a.EX_PC_SEL, 0);
    chk("rst_mem_mw", a.MEM_MEM_WRITE, 0);
    chk("rst_wb_rw", a.WB_REG_WRITE, 0);
    rst = 1'b0;
    drive(32'h00500093, 1'b1, 1'b0);
    chk("addi_stall", a.STALL, 0);
    tick();
    chk("addi_rw", a.EX_REG_WRITE, 1);
    chk("addi_alu", a.EX_ALU_FUN, 4'b0000);
    chk("addi_srcb", a.EX_ALU_SRCB, 2'b01);
    chk("addi_rfsel", a.EX_RF_SEL, 2'b11);
    chk("addi_rd", a.EX_RD, 1);
    drive(32'h0, 1'b0, 1'b0);
    tick();
    chk("addi_mem_rw", a.MEM_REG_WRITE, 1);
    chk("addi_ex_bubble", a.EX_REG_WRITE, 0);
    tick();
    chk("addi_wb_rw", a.WB_REG_WRITE, 1);
    chk("addi_wb_rd", a.WB_RD, 1);
    drive(32'h0000A103, 1'b1, 1'b0);
    tick();
    chk("lw_mr", a.EX_MEM_READ, 1);
    chk("lw_rd", a.EX_RD, 2);
    chk("lw_rfsel", a.EX_RF_SEL, 2'b10);
    drive(32'h002101B3, 1'b1, 1'b0);
    chk("lu_stall", a.STALL, 1);
    chk("lu_stall_nohaz", b.STALL, 0);
    tick();
    chk("lu_bubble_rw", a.EX_REG_WRITE, 0);
    chk("lu_bubble_mr", a.EX_MEM_READ, 0);
    chk("lu_mem_mr", a.MEM_MEM_READ, 1);
    chk("lu_stall_clear", a.STALL, 0);
    chk("lu_nohaz_rd", b.EX_RD, 3);
    tick();
    chk("add_alu", a.EX_ALU_FUN, 4'b0000);
    chk("add_rd", a.EX_RD, 3);
    chk("add_rw", a.EX_REG_WRITE, 1);
    drive(32'h4032D293, 1'b1, 1'b0);
    tick();
    chk("srai_alu", a.EX_ALU_FUN, 4'b1101);
    chk("srai_rd", a.EX_RD, 5);
    drive(32'h40838333, 1'b1, 1'b0);
    tick();
    chk("sub_alu", a.EX_ALU_FUN, 4'b1000);
    chk("sub_rd", a.EX_RD, 6);
    drive(32'h40000093, 1'b1, 1'b0);
    tick();
    chk("addi30_alu", a.EX_ALU_FUN, 4'b0000);
    chk("addi30_rw", a.EX_REG_WRITE, 1);
    drive(32'h0000A103, 1'b1, 1'b0);
    tick();
    drive(32'h002101B3, 1'b1, 1'b1);
    chk("flush_stall", a.STALL, 0);
    tick();
    chk("flush_rw", a.EX_REG_WRITE, 0);
    chk("flush_rd", a.EX_RD, 0);
    drive(32'h0, 1'b0, 1'b0);
    tick();
    chk("flush_nodup", a.EX_REG_WRITE, 0);
    chk("flush_nodup_rd", a.EX_RD, 0);
    drive(32'h00100013, 1'b1, 1'b0);
    tick();
    chk("x0_rw", a.EX_REG_WRITE, 0);
    chk("x0_rw_nosup", b.EX_REG_WRITE, 1);
    drive(32'h0000007F, 1'b1, 1'b0);
    tick();
    chk("ill_flag", a.EX_ILLEGAL, 1);
    chk("ill_rw", a.EX_REG_WRITE, 0);
    chk("ill_alu", a.EX_ALU_FUN, 0);
    chk("ill_pcsel", a.EX_PC_SEL, 0);
    chk("ill_rd", a.EX_RD, 0);
    chk("ill_flag_off", b.EX_ILLEGAL, 0);
    drive(32'h0, 1'b0, 1'b0);
    tick();
    chk("ill_one_cycle", a.EX_ILLEGAL, 0);
    drive(32'h0020A023, 1'b1, 1'b0);
    tick();
    chk("sw_mw", a.EX_MEM_WRITE, 1);
    chk("sw_rw", a.EX_REG_WRITE, 0);
    chk("sw_srcb", a.EX_ALU_SRCB, 2'b10);
    drive(32'h0, 1'b0, 1'b0);
    tick();
    chk("sw_mem_mw", a.MEM_MEM_WRITE, 1);
    chk("sw_mem_f3", a.MEM_FUNC3, 3'b010);
    rst = 1'b1;
    tick();
    chk("rst_mid_mw", a.MEM_MEM_WRITE, 0);
    chk("rst_mid_wb", a.WB_REG_WRITE, 0);
    rst = 1'b0;
    drive(32'h000000EF, 1'b1, 1'b0);
    tick();
    chk("jal_pcsel", a.EX_PC_SEL, 2'b10);
    chk("jal_rfsel", a.EX_RF_SEL, 2'b00);
    chk("jal_rw", a.EX_REG_WRITE, 1);
    drive(32'h123452B7, 1'b1, 1'b0);
    tick();
    chk("lui_rw", a.EX_REG_WRITE, 1);
    chk("lui_srca", a.EX_ALU_SRCA, 1);
    chk("lui_alu", a.EX_ALU_FUN, 4'b1001);
    drive(32'h0, 1'b0, 1'b0);
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Decode-and-carry control block for the pipelined Otter RV32I core.
- Decodes the ID-stage instruction into ALU, memory, register-file and PC-select controls.
- Registers those controls through ID/EX, EX/MEM and MEM/WB control registers.
- Detects load-use hazards and inserts bubbles on stall or flush.
- Instantiated once in the core top, beside the datapath pipeline registers.

Parameters:
HAZARD_EN, 1, 1 = load-use detection drives STALL; 0 = STALL tied 0 and no bubble is inserted for hazards.
X0_WB_SUPPRESS, 1, 1 = any instruction with rd=0 has REG_WRITE cleared at decode.
ILLEGAL_BUBBLE, 1, 1 = an unrecognised opcode enters EX as a bubble with EX_ILLEGAL=1; 0 = same, but EX_ILLEGAL stays 0.

Ports:
CLK  in  1  core clock
RST  in  1  synchronous, active-high reset
ID_IR  in  32  instruction in ID
ID_VALID  in  1  ID_IR is a real instruction
EX_FLUSH  in  1  branch/jump taken in EX; squash the ID instruction
STALL  out  1  hold PC and IF/ID this cycle
EX_REG_WRITE, EX_MEM_WRITE, EX_MEM_READ  out  1 each  EX-stage enables
EX_RF_SEL  out  2  00 = PC+4, 10 = memory, 11 = ALU
EX_ALU_FUN  out  4  ALU op
EX_ALU_SRCA  out  1  0 = rs1, 1 = U-immediate
EX_ALU_SRCB  out  2  00 = rs2, 01 = I-imm, 10 = S-imm, 11 = PC
EX_PC_SEL  out  2  00 = sequential, 01 = branch (conditional), 10 = JAL, 11 = JALR
EX_FUNC3  out  3  ir[14:12], used by branch compare and load/store size
EX_RD  out  5  destination register
EX_ILLEGAL  out  1  unrecognised opcode reached EX
MEM_REG_WRITE, MEM_MEM_WRITE, MEM_MEM_READ  out  1 each
MEM_RF_SEL  out  2
MEM_FUNC3  out  3
MEM_RD  out  5
WB_REG_WRITE  out  1
WB_RF_SEL  out  2
WB_RD  out  5

Behaviour:
Decode (combinational on ID_IR):
- R-type (0110011): ALU_FUN = {ir[30], func3}; SRCB 00; RF_SEL 11; REG_WRITE 1.
- I-ALU (0010011): SRCB 01; RF_SEL 11; REG_WRITE 1; ALU_FUN = {0, func3}.
  - Exception: func3=101 uses ALU_FUN = {ir[30], 101].
  - ADDI with ir[30]=1 must decode as 0000, never as SUB.
- Load (0000011): ALU_FUN 0000; SRCB 01; MEM_READ 1; RF_SEL 10; REG_WRITE 1.
- Store (0100011): ALU_FUN 0000; SRCB 10; MEM_WRITE 1; REG_WRITE 0.
- LUI (0110111): ALU_FUN 1001; SRCA 1; RF_SEL 11; REG_WRITE 1.
- AUIPC (0010111): ALU_FUN 0000; SRCA 1; SRCB 11; RF_SEL 11; REG_WRITE 1.
- JAL (1101111): PC_SEL 10; RF_SEL 00; REG_WRITE 1.
- JALR (1100111): PC_SEL 11; SRCB 01; RF_SEL 00; REG_WRITE 1.
- Branch (1100011): PC_SEL 01; REG_WRITE 0.
- Any other opcode: illegal, handled per ILLEGAL_BUBBLE.
- rd=0 with X0_WB_SUPPRESS=1: REG_WRITE forced 0.

Operand usage (for hazard check):
- rs1 is used by R-type, I-ALU, load, store, branch and JALR.
- rs2 is used by R-type, store and branch.

STALL (combinational):
- Asserted when HAZARD_EN=1, ID_VALID=1, EX_MEM_READ=1, EX_RD≠0, and a used rs equals EX_RD.
- EX_FLUSH=1 forces STALL=0.

ID/EX update on each rising edge, in priority order:
1. RST: all registers clear.
2. EX_FLUSH, STALL, or ID_VALID=0: load a bubble (all controls 0, RD 0, ILLEGAL 0).
3. Illegal opcode: load a bubble; EX_ILLEGAL = ILLEGAL_BUBBLE.
4. Otherwise: load the decoded controls.

Downstream registers:
- EX/MEM and MEM/WB advance unconditionally every cycle: one cycle per stage, no stall of their own.
- Latency ID→EX = 1 cycle, ID→MEM = 2 cycles, ID→WB = 3 cycles.

Reset:
- Every output register is 0 after reset: all controls 0, RD 0, PC_SEL 00, ILLEGAL 0.
- STALL is 0 during and after reset.
- Reset mid-stream discards all in-flight controls in one cycle.

Simultaneous events:
- FLUSH and hazard in the same cycle: FLUSH wins. One bubble, STALL 0.
- Back-to-back dependent loads: a single-cycle stall each. After the bubble, EX_MEM_READ=0, so STALL deasserts.

Test Plan:
- Reset, then ID_IR = 0x00500093 (addi x1,x0,5), valid. EX next cycle: REG_WRITE 1, ALU_FUN 0000, SRCB 01, RF_SEL 11, RD 1. WB asserts REG_WRITE with WB_RD=1 three cycles after ID.
- lw x2,0(x1) then add x3,x2,x2. STALL=1 for exactly one cycle while add sits in ID. EX gets a bubble, then the add (ALU_FUN 0000, RD 3). MEM_MEM_READ=1 in the bubble cycle.
- srai x5,x5,3 (0x4032D293) → ALU_FUN 1101. sub x6,x7,x8 → ALU_FUN 1000. addi with ir[30]=1 (0x40000093) → ALU_FUN 0000.
- lw x2 in EX, dependent add in ID, and EX_FLUSH=1 in the same cycle. STALL=0, EX bubble, no duplicate add afterwards. Also check: addi x0,x0,1 → EX_REG_WRITE 0.
- Opcode 0x7F with ILLEGAL_BUBBLE=1 → EX_ILLEGAL=1 for one cycle, all other controls 0. Same with HAZARD_EN=0 and the load-use pair → STALL stays 0.
- RST asserted while a store occupies MEM → MEM_MEM_WRITE=0 the next cycle. JAL → EX_PC_SEL 10, RF_SEL 00. LUI → REG_WRITE 1, SRCA 1.
